product_accumulator: RTL and testbench

//  Downstream consumer of the 2x2 array multiplier's 4-bit product (z, range 0..9).

---
 rtl/product_accumulator.sv | 57 +++++
 tb/tb_product_accumulator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS handshaked multiplier products and presents the total on a valid/ready output
module product_accumulator #(
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(N_TERMS) + 1;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] add;
  logic accept, last, clr;
  assign add = {1'b0, acc} + (ACC_W+1)'(prod);
  assign last = cnt == CW'(N_TERMS - 1);
  assign sum = acc;
  always_comb begin
    in_ready = state == ACC;
    sum_valid = state == HOLD;
    busy = state != IDLE;
    accept = in_valid && in_ready;
    clr = start && (state == IDLE || (state == HOLD && sum_ready));
    state_nx = clr ? ACC :
               (state == ACC && accept && last) ? HOLD :
               (state == HOLD && sum_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        acc <= add[ACC_W-1:0];
        cnt <= cnt + 1'b1;
        overflow <= overflow | add[ACC_W];
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives an 8-bit and a 5-bit accumulator in lockstep against an integer-sum model
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] prod = 4'd0;
  logic in_valid = 1'b0;
  logic sum_ready = 1'b0;
  logic in_ready8, sum_valid8, overflow8, busy8;
  logic in_ready5, sum_valid5, overflow5, busy5;
  logic [7:0] sum8;
  logic [4:0] sum5;
  int checks = 0;
  int failures = 0;

  product_accumulator dut8 (
    .clk(clk), .rst(rst), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready8), .sum(sum8), .sum_valid(sum_valid8), .sum_ready(sum_ready),
    .overflow(overflow8), .busy(busy8)
  );

  product_accumulator #(.ACC_W(5), .N_TERMS(4)) dut5 (
    .clk(clk), .rst(rst), .start(start), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready5), .sum(sum5), .sum_valid(sum_valid5), .sum_ready(sum_ready),
    .overflow(overflow5), .busy(busy5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run: total is the plain arithmetic sum; each width sees it modulo 2^W, overflow iff total reaches 2^W
  task automatic run(input int p[4], input int gap, input int hold, input bit chain, input bit skip_start);
    int total = 0;
    if (!skip_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_flags", {in_ready8, in_ready5, busy8, busy5, sum_valid8, sum_valid5, overflow8, overflow5}, 8'b11110000);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bubble_flags", {in_ready8, in_ready5, sum_valid8, sum_valid5}, 4'b1100);
      end
      in_valid = 1'b1;
      prod = 4'(p[i]);
      tick();
      total += p[i];
      in_valid = 1'b0;
      if (i < 3) chk("mid_flags", {in_ready8, in_ready5, sum_valid8, sum_valid5}, 4'b1100);
    end
    chk("hold_flags", {sum_valid8, sum_valid5, in_ready8, in_ready5, busy8, busy5}, 6'b110011);
    chk("sum8", 32'(sum8), total % 256);
    chk("sum5", 32'(sum5), total % 32);
    chk("ov8", 32'(overflow8), 32'(total >= 256));
    chk("ov5", 32'(overflow5), 32'(total >= 32));
    repeat (hold) begin
      in_valid = 1'b1;
      prod = 4'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("stall_sum8", 32'(sum8), total % 256);
      chk("stall_sum5", 32'(sum5), total % 32);
      chk("stall_flags", {sum_valid8, sum_valid5, in_ready8, in_ready5}, 4'b1100);
    end
    in_valid = 1'b0;
    sum_ready = 1'b1;
    start = chain;
    tick();
    sum_ready = 1'b0;
    start = 1'b0;
    if (chain) begin
      chk("chain_flags", {in_ready8, in_ready5, sum_valid8, sum_valid5, overflow8, overflow5}, 6'b110000);
      chk("chain_acc", {24'd0, sum8}, {27'd0, sum5});
      chk("chain_acc0", 32'(sum8), 0);
    end else begin
      chk("idle_flags", {in_ready8, in_ready5, sum_valid8, sum_valid5, busy8, busy5}, 6'b0);
    end
  endtask

  initial begin
    int p[4];
    bit chained;
    #1;
    chk("reset_flags", {in_ready8, in_ready5, sum_valid8, sum_valid5, busy8, busy5, overflow8, overflow5}, 8'b0);
    chk("reset_sum", {24'd0, sum8} | {27'd0, sum5}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {in_ready8, busy8, sum_valid8}, 3'b0);
    run('{3, 4, 6, 9}, 0, 0, 1'b0, 1'b0);
    run('{3, 4, 6, 9}, 2, 0, 1'b0, 1'b0);
    run('{9, 9, 9, 9}, 0, 0, 1'b0, 1'b0);
    run('{3, 4, 6, 9}, 0, 5, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      prod = 4'd5;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {in_ready8, in_ready5, sum_valid8, sum_valid5, busy8, busy5, overflow8, overflow5}, 8'b0);
    chk("async_reset_sum", {24'd0, sum8} | {27'd0, sum5}, 0);
    rst = 1'b0;
    tick();
    run('{1, 1, 1, 1}, 0, 0, 1'b0, 1'b0);
    run('{9, 9, 9, 9}, 0, 0, 1'b1, 1'b0);
    run('{2, 2, 2, 2}, 0, 0, 1'b0, 1'b1);
    chained = 1'b0;
    for (int r = 0; r < 24; r++) begin
      bit ch;
      for (int i = 0; i < 4; i++) p[i] = int'($urandom_range(0, 15));
      ch = 1'($urandom_range(0, 1));
      run(p, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ch, chained);
      chained = ch;
    end
    if (chained) run('{0, 0, 0, 0}, 0, 0, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
